led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 Parameter: TICK_DIV, default 100000, clock cycles per duration tick; legal range 1 to 2^24-1.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  level-sampled; begins a program run from address 0.
REQ-006 Port: stop  input  1  level-sampled; aborts a run.
REQ-007 Port: addrRd  output  8  program ROM address, registered.
REQ-008 Port: dataRd  input  16  ROM word; combinational response to addrRd; bits [15:8] are the LED pattern; bits [7:0] are the duration in ticks.
REQ-009 Port: leds  output  8  registered LED pattern.
REQ-010 Port: busy  output  1  high in the FETCH and SHOW states.
REQ-011 Port: done  output  1  high in the DONE state.

Function
REQ-012 The state machine SHALL have four states: IDLE, FETCH, SHOW and DONE.
REQ-013 IDLE: when start=1 and stop=0, the block SHALL set addrRd to 0 and move to FETCH on the next edge.
REQ-014 FETCH lasts exactly one cycle, during which the block SHALL sample dataRd.
REQ-015 In FETCH, if duration is not 0: leds take the pattern field, the duration counter loads the duration field, the prescaler clears, and the state moves to SHOW.
REQ-016 In FETCH, if duration is 0: this is the end marker, and the behaviour is set by REQ-027/REQ-028.
REQ-017 SHOW: the prescaler SHALL pulse once every TICK_DIV cycles, and each pulse SHALL decrement the duration counter.
REQ-018 In SHOW, the pulse that takes the counter from 1 to 0 SHALL increment addrRd (mod 256; 255 wraps to 0) and move the state to FETCH.
REQ-019 Each non-zero instruction SHALL occupy exactly duration*TICK_DIV + 1 cycles, FETCH included.
REQ-020 leds SHALL hold the previous pattern during FETCH, with no glitch to 0.
REQ-021 If stop=1 in any state, the next state SHALL be IDLE and leds SHALL be 0; if start and stop are both asserted, stop wins.
REQ-022 start SHALL be ignored in FETCH and SHOW.
REQ-023 In DONE, start=1 SHALL restart the program exactly as from IDLE.
REQ-024 DONE SHALL drive leds=0 and hold addrRd at the end-marker address.

Reset
REQ-025 On reset=1, the block SHALL go to state IDLE and set addrRd=0, leds=0, busy=0, done=0, the duration counter to 0 and the prescaler to 0.
REQ-026 A reset asserted mid-run SHALL take priority over start and stop and SHALL discard the run entirely.

Configuration
REQ-027 With macro LED_SEQUENCER_LOOP_EN defined: an end marker at an address other than 0 SHALL set addrRd to 0 and return to FETCH; done never asserts except when the end marker is at address 0, which goes to DONE to prevent an infinite fetch loop.
REQ-028 With LED_SEQUENCER_LOOP_EN undefined: an end marker SHALL always go to DONE.

Structure
REQ-029 Package led_seq_pkg SHALL hold the state enum, the field positions (PAT_MSB=15, PAT_LSB=8, DUR_MSB=7, DUR_LSB=0), ADDR_W=8, DATA_W=16 and the default TICK_DIV.
REQ-030 The prescaler SHALL be a separate sub-module, tick_prescaler, with inputs clk, reset and clr, and a one-cycle tick output.

Verification
REQ-031 Bench SHALL use TICK_DIV=2 with a ROM whose addresses 0..7 hold {1<<(7-i), 8'd128} and whose default word is 0.
REQ-032 Scenario: reset, then a start pulse at cycle 0 -> addrRd=0 and busy=1 at cycle 1; leds=8'h80 at cycle 2; addrRd=1 at cycle 258.
REQ-033 Scenario: full run without loop -> the pattern walks 80, 40, ..., 01; the end marker at addr 8 is fetched at cycle 2057; done=1 and leds=0 at cycle 2058.
REQ-034 Scenario: full run with LED_SEQUENCER_LOOP_EN -> after addr 8 the next addrRd=0 and leds returns to 8'h80; done stays 0.
REQ-035 Scenario: stop at cycle 100, with start also held high -> IDLE, leds=0 and busy=0 next cycle; the run does not restart while stop=1.
REQ-036 Scenario: ROM word 0 = 16'h5500 (end marker at addr 0), then start -> DONE after FETCH in both configurations.
REQ-037 Scenario: reset pulsed at cycle 300 mid-SHOW -> all outputs are at reset values next cycle; a later start replays from addr 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
// Holds the FSM state enum, ROM word field positions and widths.
package led_seq_pkg;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 16;
  localparam int PAT_MSB      = 15;
  localparam int PAT_LSB      = 8;
  localparam int DUR_MSB      = 7;
  localparam int DUR_LSB      = 0;
  localparam int DEF_TICK_DIV = 100000;
  localparam int CNT_W        = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHOW,
    ST_DONE
  } state_t;

  function automatic logic [7:0] pat_of(
    input logic [DATA_W-1:0] w
  );
    return w[PAT_MSB:PAT_LSB];
  endfunction

  function automatic logic [7:0] dur_of(
    input logic [DATA_W-1:0] w
  );
    return w[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV into a one-cycle tick.
// Ports: clk, reset (sync, active-high), clr (restart count), tick.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == LAST);
  assign tick = wrap & ~clr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: plays a ROM program of {pattern, duration} words
// onto leds. Ports: clk, reset, start, stop, addrRd/dataRd (ROM),
// leds, busy, done. Macro LED_SEQUENCER_LOOP_EN makes a non-zero
// address end marker loop back to address 0 instead of finishing.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] addrRd,
  input  logic [DATA_W-1:0] dataRd,
  output logic [7:0]        leds,
  output logic              busy,
  output logic              done
);

`ifdef LED_SEQUENCER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t     state;
  state_t     state_nx;
  logic [7:0] dur_cnt;
  logic [7:0] pat;
  logic [7:0] dur;
  logic       tick;
  logic       clr;
  logic       is_marker;
  logic       loop_back;
  logic       end_run;
  logic       last_tick;

  assign pat       = pat_of(dataRd);
  assign dur       = dur_of(dataRd);
  assign is_marker = (dur == 8'd0);
  // A marker at address 0 would refetch itself forever, so it ends.
  assign loop_back = is_marker & LOOP_EN & (|addrRd);
  assign end_run   = is_marker & ~loop_back;
  assign last_tick = tick & (dur_cnt == 8'd1);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) state_nx = ST_FETCH;
        end
        ST_FETCH: begin
          unique case (1'b1)
            !is_marker: state_nx = ST_SHOW;
            loop_back:  state_nx = ST_FETCH;
            end_run:    state_nx = ST_DONE;
          endcase
        end
        ST_SHOW: begin
          if (last_tick) state_nx = ST_FETCH;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    clr  = 1'b1;
    unique case (state)
      ST_FETCH: busy = 1'b1;
      ST_SHOW: begin
        busy = 1'b1;
        clr  = 1'b0;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: leds only change on a fetch, a finish or an abort,
  // so the previous pattern stays up through FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrRd  <= '0;
      leds    <= '0;
      dur_cnt <= '0;
    end else if (stop) begin
      leds    <= '0;
      dur_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) addrRd <= '0;
        end
        ST_FETCH: begin
          unique case (1'b1)
            !is_marker: begin
              leds    <= pat;
              dur_cnt <= dur;
            end
            loop_back: addrRd <= '0;
            end_run:   leds   <= '0;
          endcase
        end
        ST_SHOW: begin
          if (tick) dur_cnt <= dur_cnt - 8'd1;
          if (last_tick) addrRd <= addrRd + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized self-checking bench for led_sequencer.
// Expected outputs come from a program-walk model of the ROM.
module tb_led_sequencer;

  localparam int DIV = 2;
`ifdef LED_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  addrRd;
  logic [15:0] dataRd;
  logic [7:0]  leds;
  logic        busy;
  logic        done;
  logic [17:0] obs;
  logic [17:0] exp;
  logic [15:0] rom [256];
  int          errors = 0;
  int          checks = 0;
  int          t;

  assign dataRd = rom[addrRd];
  assign obs    = {addrRd, leds, busy, done};

  always #5 clk = ~clk;

  led_sequencer #(
    .TICK_DIV(DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .addrRd(addrRd),
    .dataRd(dataRd),
    .leds  (leds),
    .busy  (busy),
    .done  (done)
  );

  // Expected {addr, leds, busy, done} in cycle tc of a run whose
  // start was sampled at the edge closing cycle 0.
  function automatic logic [17:0] model(input int tc);
    int         pos = 1;
    int         d;
    logic [7:0] a = 8'd0;
    logic [7:0] prev = 8'd0;
    logic [7:0] p;
    for (int it = 0; it < 100000; it++) begin
      p = rom[a][15:8];
      d = int'(rom[a][7:0]);
      if (tc == pos) return {a, prev, 2'b10};
      if (d == 0) begin
        if (LOOP && a != 8'd0) begin
          a = 8'd0;
          pos = pos + 1;
          continue;
        end
        return {a, 8'h00, 2'b01};
      end
      if (tc <= pos + d * DIV) return {a, p, 2'b10};
      prev = p;
      pos = pos + d * DIV + 1;
      a = a + 8'd1;
    end
    return '0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rom[i] = {8'(1 << (7 - i)), 8'd128};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic kick();
    t = 0;
    start = 1'b1;
    stop  = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    stop  = 1'b0;
    step();
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs, 18'h0);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", obs, 18'h0);
    end
  endtask

  task automatic test_full_run();
    logic [17:0] want;
    load_rom();
    do_reset();
    kick();
    while (t <= 2062) begin
      exp = model(t);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL full_run t=%0d got=%h want=%h", t, obs, exp);
      end
      if (t == 1 || t == 2 || t == 258 || t == 2057
          || t == 2058 || t == 2059) begin
        unique case (t)
          1:    want = {8'd0, 8'h00, 2'b10};
          2:    want = {8'd0, 8'h80, 2'b10};
          258:  want = {8'd1, 8'h80, 2'b10};
          2057: want = {8'd8, 8'h01, 2'b10};
          2058: want = LOOP ? {8'd0, 8'h01, 2'b10}
                            : {8'd8, 8'h00, 2'b01};
          default: want = LOOP ? {8'd0, 8'h80, 2'b10}
                               : {8'd8, 8'h00, 2'b01};
        endcase
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL full_run_mark t=%0d got=%h want=%h",
                   t, obs, want);
        end
      end
      step();
    end
  endtask

  task automatic test_stop();
    load_rom();
    do_reset();
    kick();
    while (t < 100) begin
      exp = model(t);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stop_pre t=%0d got=%h want=%h", t, obs, exp);
      end
      step();
    end
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (obs[9:0] !== 10'h0) begin
        errors++;
        $display("FAIL stop_idle t=%0d got=%h want=%h",
                 t, obs[9:0], 10'h0);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    step();
    checks++;
    if (obs[9:0] !== 10'h0) begin
      errors++;
      $display("FAIL stop_release got=%h want=%h", obs[9:0], 10'h0);
    end
  endtask

  task automatic test_reset_mid();
    load_rom();
    do_reset();
    kick();
    while (t < 300) begin
      exp = model(t);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rmid_pre t=%0d got=%h want=%h", t, obs, exp);
      end
      step();
    end
    reset = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    step();
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL rmid_reset got=%h want=%h", obs, 18'h0);
    end
    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    step();
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL rmid_idle got=%h want=%h", obs, 18'h0);
    end
    kick();
    while (t <= 300) begin
      exp = model(t);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rmid_replay t=%0d got=%h want=%h",
                 t, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_marker_zero();
    load_rom();
    rom[0] = 16'h5500;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      kick();
      checks++;
      if (obs !== {8'd0, 8'h00, 2'b10}) begin
        errors++;
        $display("FAIL mark0_fetch r=%0d got=%h want=%h",
                 r, obs, {8'd0, 8'h00, 2'b10});
      end
      for (int i = 0; i < 3; i++) begin
        step();
        checks++;
        if (obs !== {8'd0, 8'h00, 2'b01}) begin
          errors++;
          $display("FAIL mark0_done r=%0d t=%0d got=%h want=%h",
                   r, t, obs, {8'd0, 8'h00, 2'b01});
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'd1};
    do_reset();
    kick();
    while (t <= 800) begin
      exp = model(t);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap t=%0d got=%h want=%h", t, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        rom[i] = {8'($urandom), 8'($urandom_range(1, 4))};
      end
      do_reset();
      kick();
      while (t <= 90) begin
        exp = model(t);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random k=%0d t=%0d got=%h want=%h",
                   k, t, obs, exp);
        end
        start = exp[1] ? 1'($urandom % 2) : 1'b0;
        step();
      end
      start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    t     = 0;
    load_rom();
    @(negedge clk);
    test_reset();
    test_full_run();
    test_stop();
    test_reset_mid();
    test_marker_zero();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
